// File: rtl/fp_cpu.sv
// rtl/fp_cpu.sv - multi-cycle single-precision FP add/sub processor
//
// Purpose: fetches 59-bit instructions from a 32-entry instruction memory,
// reads operands from a 32x32 register file, performs an IEEE-754 single
// precision add (truncating, denormals flushed) and writes the result back.
// Each instruction takes four cycles: FETCH, DECODE, EXECUTE, WRITEBACK.
//
// Optional feature macro: FP_SUB_EN (opcode 00001 performs A - B when defined,
// otherwise it is a NOP).
//
// Ports (fp_cpu):
//   clk                 in   1   clock, rising edge
//   rst                 in   1   synchronous active-high reset
//   pc                  out  5   current program counter
//   fetch_stage_enable  out  1   high during the FETCH cycle
//   wb_valid            out  1   pulse in WRITEBACK when a register is written
//   wb_addr             out  5   last written destination register
//   wb_data             out  32  last written data
//
// Sub-modules: fp_pc_imem (instance pc_inst), fp_ctrl (instance
// top_cont_inst) which holds fp_regfile (instance reg_inst).

// Program counter plus instruction memory. The write port exists so the
// array has a driver in the design; the top level ties it off and the
// contents are normally preloaded hierarchically.
module fp_pc_imem #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [58:0]     wdata,
  output logic [PC_W-1:0] pc,
  output logic [58:0]     instr
);
  logic [58:0]     Imem [0:IMEM_DEPTH-1];
  logic [PC_W-1:0] pc_q, pc_d;

  // PC_W-bit increment wraps naturally from the last entry back to 0.
  always_comb begin
    pc_d = pc_q;
    if (advance) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (we) Imem[waddr] <= wdata;
  end

  assign pc    = pc_q;
  assign instr = Imem[pc_q];
endmodule

// Register file: two asynchronous read ports, one synchronous write port.
// Not reset, so preloaded contents survive rst.
module fp_regfile #(
  parameter int NUM_REGS = 32,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic [RA_W-1:0] raddr1,
  input  logic [RA_W-1:0] raddr2,
  output logic [31:0]     rdata1,
  output logic [31:0]     rdata2,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [31:0]     wdata
);
  logic [31:0] Registers [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (we) Registers[waddr] <= wdata;
  end

  assign rdata1 = Registers[raddr1];
  assign rdata2 = Registers[raddr2];
endmodule

// Control FSM, operand/result registers and the FP adder.
module fp_ctrl #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [58:0] instr,
  output logic        advance,
  output logic        fetch_stage_enable,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);
  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      state_q, state_d;
  logic [58:0] instr_q, instr_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic        valid_q, valid_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;

  // Instruction fields
  logic [1:0]  f_flag;
  logic [4:0]  f_op, f_rd, f_rs1, f_rs2;
  logic [31:0] f_imm;
  logic        unused_tag;

  assign f_flag     = instr_q[58:57];
  assign f_op       = instr_q[56:52];
  assign f_rd       = instr_q[51:47];
  assign f_rs1      = instr_q[46:42];
  assign f_rs2      = instr_q[41:37];
  assign f_imm      = instr_q[31:0];
  assign unused_tag = ^instr_q[36:32];

  logic [31:0] rdata1, rdata2;
  logic        rf_we;

  fp_regfile #(.NUM_REGS(NUM_REGS)) reg_inst (
    .clk    (clk),
    .raddr1 (f_rs1),
    .raddr2 (f_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (rf_we),
    .waddr  (f_rd),
    .wdata  (res_q)
  );

  // Opcode decode; flag 1x is a NOP regardless of opcode.
  logic is_add, is_sub, op_valid;
  assign is_add = ~f_flag[1] && (f_op == 5'b00000);
`ifdef FP_SUB_EN
  assign is_sub = ~f_flag[1] && (f_op == 5'b00001);
`else
  assign is_sub = 1'b0;
`endif
  assign op_valid = is_add | is_sub;

  // ---------------- FP adder (combinational, from a_q/b_q) ----------------
  logic [31:0] b_eff, fp_res;
  logic [7:0]  ea, eb, e_big, e_small, shamt;
  logic        big_is_a, s_big;
  logic [23:0] m_big, m_small, m_small_al, mag_diff, mant_norm;
  logic [24:0] mag_sum;
  logic [4:0]  lead, norm_shift;
  logic [9:0]  exp_sum, exp_diff;

  always_comb begin
    // Subtraction reuses the adder with B's sign inverted.
    b_eff    = is_sub ? {~b_q[31], b_q[30:0]} : b_q;
    ea       = a_q[30:23];
    eb       = b_eff[30:23];
    // Magnitude compare on exponent+fraction picks the larger operand, so
    // the mantissa difference below is never negative.
    big_is_a = (a_q[30:0] >= b_eff[30:0]);
    e_big    = big_is_a ? ea : eb;
    e_small  = big_is_a ? eb : ea;
    s_big    = big_is_a ? a_q[31] : b_eff[31];
    m_big    = big_is_a ? {1'b1, a_q[22:0]} : {1'b1, b_eff[22:0]};
    m_small  = big_is_a ? {1'b1, b_eff[22:0]} : {1'b1, a_q[22:0]};
    shamt    = e_big - e_small;
    m_small_al = (shamt >= 8'd25) ? 24'd0 : (m_small >> shamt);

    mag_sum  = {1'b0, m_big} + {1'b0, m_small_al};
    mag_diff = m_big - m_small_al;

    // Leading-one search: the highest set bit wins.
    lead = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (mag_diff[i]) lead = i[4:0];
    end
    norm_shift = 5'd23 - lead;
    mant_norm  = mag_diff << norm_shift;

    exp_sum  = {2'b00, e_big} + {9'd0, mag_sum[24]};
    exp_diff = {2'b00, e_big} - {5'd0, norm_shift};

    fp_res = 32'h0000_0000;
    if (ea == 8'hFF || eb == 8'hFF) begin
      fp_res = 32'h7FC0_0000;
    end else if (ea == 8'h00) begin
      fp_res = b_eff;
    end else if (eb == 8'h00) begin
      fp_res = a_q;
    end else if (a_q[31] == b_eff[31]) begin
      if (exp_sum >= 10'd255)
        fp_res = {s_big, 8'hFF, 23'd0};
      else
        fp_res = {s_big, exp_sum[7:0], mag_sum[24] ? mag_sum[23:1] : mag_sum[22:0]};
    end else if (mag_diff == 24'd0) begin
      fp_res = 32'h0000_0000;
    end else if (exp_diff[9] || exp_diff == 10'd0) begin
      // Underflow below the smallest normal exponent flushes to +0.
      fp_res = 32'h0000_0000;
    end else begin
      fp_res = {s_big, exp_diff[7:0], mant_norm[22:0]};
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Gated by rst so nothing is written or announced on a resetting edge.
  always_comb begin
    fetch_stage_enable = (state_q == S_FETCH) && !rst;
    wb_valid           = (state_q == S_WB) && valid_q && !rst;
    rf_we              = wb_valid;
    advance            = (state_q == S_WB);
  end

  // ---------------- Datapath registers ----------------
  always_comb begin
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    valid_d   = valid_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_FETCH:  instr_d = instr;
      S_DECODE: begin
        a_d = rdata1;
        b_d = (f_flag == 2'b01) ? f_imm : rdata2;
      end
      S_EXEC: begin
        res_d   = fp_res;
        valid_d = op_valid;
      end
      S_WB: begin
        if (valid_q) begin
          wb_addr_d = f_rd;
          wb_data_d = res_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      valid_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // During the WRITEBACK pulse the new destination/data are shown directly;
  // otherwise the last written pair is held.
  assign wb_addr = wb_valid ? f_rd  : wb_addr_q;
  assign wb_data = wb_valid ? res_q : wb_data_q;
endmodule

module fp_cpu #(
  parameter int IMEM_DEPTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  pc,
  output logic        fetch_stage_enable,
  output logic        wb_valid,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);
  logic        advance;
  logic [58:0] instr;

  fp_pc_imem #(.IMEM_DEPTH(IMEM_DEPTH), .PC_W(5)) pc_inst (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .we      (1'b0),
    .waddr   (5'd0),
    .wdata   (59'd0),
    .pc      (pc),
    .instr   (instr)
  );

  fp_ctrl #(.NUM_REGS(NUM_REGS)) top_cont_inst (
    .clk                (clk),
    .rst                (rst),
    .instr              (instr),
    .advance            (advance),
    .fetch_stage_enable (fetch_stage_enable),
    .wb_valid           (wb_valid),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data)
  );
endmodule

// File: tb/tb_fp_cpu.sv
// tb/tb_fp_cpu.sv - directed self-checking bench for fp_cpu
module tb_fp_cpu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  pc;
  logic        fetch_stage_enable;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  fp_cpu dut (
    .clk                (clk),
    .rst                (rst),
    .pc                 (pc),
    .fetch_stage_enable (fetch_stage_enable),
    .wb_valid           (wb_valid),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [58:0] mk(input logic [1:0] f, input logic [4:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm);
    return {f, op, rd, rs1, rs2, 5'd0, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in a FETCH cycle; leaves in the following FETCH cycle.
  task automatic run_instr(output int fse_cnt, output logic wv,
                           output logic [4:0] wa, output logic [31:0] wd);
    fse_cnt = 0;
    fse_cnt += int'(fetch_stage_enable);
    step();
    fse_cnt += int'(fetch_stage_enable);
    step();
    fse_cnt += int'(fetch_stage_enable);
    step();
    fse_cnt += int'(fetch_stage_enable);
    wv = wb_valid;
    wa = wb_addr;
    wd = wb_data;
    step();
  endtask

  initial begin
    int          fc, fse_total, wv_total;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;

    for (int i = 0; i < 32; i++) begin
      dut.pc_inst.Imem[i]                  = mk(2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      dut.top_cont_inst.reg_inst.Registers[i] = 32'd0;
    end
    dut.top_cont_inst.reg_inst.Registers[1]  = 32'h4000_0000;
    dut.top_cont_inst.reg_inst.Registers[2]  = 32'h4040_0000;
    dut.top_cont_inst.reg_inst.Registers[4]  = 32'h1234_5678;
    dut.top_cont_inst.reg_inst.Registers[5]  = 32'hC000_0000;
    dut.top_cont_inst.reg_inst.Registers[6]  = 32'hDEAD_BEEF;
    dut.top_cont_inst.reg_inst.Registers[8]  = 32'h7F80_0000;
    dut.top_cont_inst.reg_inst.Registers[9]  = 32'h7F7F_FFFF;
    dut.top_cont_inst.reg_inst.Registers[11] = 32'h3F80_0000;
    dut.top_cont_inst.reg_inst.Registers[12] = 32'h3300_0000;
    dut.top_cont_inst.reg_inst.Registers[14] = 32'h1111_1111;

    dut.pc_inst.Imem[0] = mk(2'b00, 5'd0, 5'd3,  5'd1,  5'd2,  32'd0);
    dut.pc_inst.Imem[1] = mk(2'b01, 5'd0, 5'd3,  5'd1,  5'd2,  32'd0);
    dut.pc_inst.Imem[2] = mk(2'b00, 5'd1, 5'd4,  5'd2,  5'd1,  32'd0);
    dut.pc_inst.Imem[3] = mk(2'b00, 5'd0, 5'd6,  5'd1,  5'd5,  32'd0);
    dut.pc_inst.Imem[4] = mk(2'b00, 5'd0, 5'd7,  5'd1,  5'd8,  32'd0);
    dut.pc_inst.Imem[5] = mk(2'b00, 5'd0, 5'd10, 5'd9,  5'd9,  32'd0);
    dut.pc_inst.Imem[6] = mk(2'b00, 5'd0, 5'd13, 5'd11, 5'd12, 32'd0);
    dut.pc_inst.Imem[7] = mk(2'b00, 5'd0, 5'd14, 5'd1,  5'd2,  32'd0);

    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_fse", 32'(fetch_stage_enable), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_fetch_fse", 32'(fetch_stage_enable), 32'd1);

    // Imem[0]: R3 = 2.0 + 3.0
    run_instr(fc, wv, wa, wd);
    chk("add_wv", 32'(wv), 32'd1);
    chk("add_wa", 32'(wa), 32'd3);
    chk("add_wd", wd, 32'h40A0_0000);
    chk("add_fse_once", 32'(fc), 32'd1);
    chk("add_pc", 32'(pc), 32'd1);
    chk("add_r3", dut.top_cont_inst.reg_inst.Registers[3], 32'h40A0_0000);
    chk("hold_wa", 32'(wb_addr), 32'd3);
    chk("hold_wv_low", 32'(wb_valid), 32'd0);

    // Imem[1]: immediate zero -> A passes through
    run_instr(fc, wv, wa, wd);
    chk("imm_wd", wd, 32'h4000_0000);
    chk("imm_r3", dut.top_cont_inst.reg_inst.Registers[3], 32'h4000_0000);
    chk("imm_fse_once", 32'(fc), 32'd1);

    // Imem[2]: R4 = R2 - R1
    run_instr(fc, wv, wa, wd);
`ifdef FP_SUB_EN
    chk("sub_wv", 32'(wv), 32'd1);
    chk("sub_r4", dut.top_cont_inst.reg_inst.Registers[4], 32'h3F80_0000);
`else
    chk("sub_nop_wv", 32'(wv), 32'd0);
    chk("sub_nop_r4", dut.top_cont_inst.reg_inst.Registers[4], 32'h1234_5678);
    chk("sub_nop_wa_hold", 32'(wa), 32'd3);
`endif

    // Imem[3]: 2.0 + (-2.0) cancels to +0
    run_instr(fc, wv, wa, wd);
    chk("cancel_wd", wd, 32'h0000_0000);
    chk("cancel_r6", dut.top_cont_inst.reg_inst.Registers[6], 32'h0000_0000);

    // Imem[4]: Inf operand -> quiet NaN
    run_instr(fc, wv, wa, wd);
    chk("nan_r7", dut.top_cont_inst.reg_inst.Registers[7], 32'h7FC0_0000);

    // Imem[5]: max finite + max finite -> +Inf
    run_instr(fc, wv, wa, wd);
    chk("ovf_r10", dut.top_cont_inst.reg_inst.Registers[10], 32'h7F80_0000);

    // Imem[6]: 1.0 + 2^-25, shift of 25 drops the small operand
    run_instr(fc, wv, wa, wd);
    chk("align_r13", dut.top_cont_inst.reg_inst.Registers[13], 32'h3F80_0000);
    chk("pc_after7", 32'(pc), 32'd7);

    // Imem[7]: reset during EXECUTE aborts the write to R14
    step();
    step();
    rst = 1'b1;
    step();
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_wv", 32'(wb_valid), 32'd0);
    chk("midrst_wa", 32'(wb_addr), 32'd0);
    chk("midrst_wd", wb_data, 32'd0);
    chk("midrst_r14", dut.top_cont_inst.reg_inst.Registers[14], 32'h1111_1111);
    chk("midrst_r13", dut.top_cont_inst.reg_inst.Registers[13], 32'h3F80_0000);
    rst = 1'b0;
    #1;

    // Restart at Imem[0]
    run_instr(fc, wv, wa, wd);
    chk("restart_wv", 32'(wv), 32'd1);
    chk("restart_wd", wd, 32'h40A0_0000);
    chk("restart_pc", 32'(pc), 32'd1);
    chk("restart_r14", dut.top_cont_inst.reg_inst.Registers[14], 32'h1111_1111);

    // All NOPs: PC wraps, nothing written
    for (int i = 0; i < 32; i++)
      dut.pc_inst.Imem[i] = mk(2'b11, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    fse_total = 0;
    wv_total  = 0;
    for (int i = 0; i < 31; i++) begin
      run_instr(fc, wv, wa, wd);
      fse_total += fc;
      wv_total  += int'(wv);
    end
    chk("wrap_pc0", 32'(pc), 32'd0);
    run_instr(fc, wv, wa, wd);
    fse_total += fc;
    wv_total  += int'(wv);
    chk("wrap_pc1", 32'(pc), 32'd1);
    chk("nop_wv_count", 32'(wv_total), 32'd0);
    chk("nop_fse_count", 32'(fse_total), 32'd32);
    chk("nop_r3", dut.top_cont_inst.reg_inst.Registers[3], 32'h40A0_0000);
    chk("nop_r1", dut.top_cont_inst.reg_inst.Registers[1], 32'h4000_0000);
    chk("nop_wa_hold", 32'(wb_addr), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
